// File: rtl/mem_stage_lat.sv
// mem_stage_lat: EX->WB memory stage with sub-word load extraction and variable-latency read wait.
// Optional misaligned-access trap enabled by MEM_ALIGN_CHECK_EN.
module mem_stage_lat #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15,
  parameter int RF_AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        in_mem_op,
  input  logic              in_sel_rf_res,
  input  logic              in_rf_we,
  input  logic [RF_AW-1:0]  in_rf_waddr,
  input  logic [DATA_W-1:0] in_ex_result,
  input  logic              data_rvalid,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              stall_req,
  output logic              wb_valid,
  output logic [31:0]       wb_pc,
  output logic              wb_rf_we,
  output logic [RF_AW-1:0]  wb_rf_waddr,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic              mem_timeout,
  output logic              align_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [4:0]        op;
    logic              sel;
    logic              we;
    logic [RF_AW-1:0]  waddr;
    logic [DATA_W-1:0] res;
  } stage_t;
  stage_t stage_q, stage_d;
  state_t state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, ext;
  logic timeout_q, align_q, cap, is_load, mis;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign stage_d = in_valid ? {1'b1, in_pc, in_mem_op, in_sel_rf_res, in_rf_we, in_rf_waddr, in_ex_result} : '0;
  assign cap = !hold && state_q != WAIT;
  assign is_load = in_valid && |in_mem_op;
  assign cnt_d = cnt_q + CW'(1);
`ifdef MEM_ALIGN_CHECK_EN
  assign mis = is_load && ((|in_mem_op[2:1] && in_ex_result[0]) || (in_mem_op[0] && |in_ex_result[1:0]));
`else
  assign mis = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stage_q   <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      align_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (cap) begin
        stage_q <= stage_d;
        align_q <= mis;
        rdata_q <= '0;
        cnt_q   <= '0;
        state_q <= mis ? DONE : is_load ? WAIT : IDLE;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_d;
        if (data_rvalid) begin
          rdata_q <= data_rdata;
          state_q <= DONE;
        end else if (cnt_d == MAX_C) begin
          rdata_q   <= '0;
          timeout_q <= 1'b1;
          state_q   <= DONE;
        end
      end
    end
  end
  // Little-endian: byte lane selected by off, halfword lane by off[1].
  always_comb begin
    byte_v = rdata_q[{stage_q.res[1:0], 3'b000} +: 8];
    half_v = stage_q.res[1] ? rdata_q[31:16] : rdata_q[15:0];
    ext = stage_q.op[4] ? {{(DATA_W-8){byte_v[7]}}, byte_v} :
          stage_q.op[3] ? {{(DATA_W-8){1'b0}}, byte_v} :
          stage_q.op[2] ? {{(DATA_W-16){half_v[15]}}, half_v} :
          stage_q.op[1] ? {{(DATA_W-16){1'b0}}, half_v} : rdata_q;
  end
  assign stall_req   = state_q == WAIT;
  assign wb_valid    = state_q == DONE || (state_q == IDLE && stage_q.valid);
  assign wb_pc       = stage_q.pc;
  assign wb_rf_we    = wb_valid && stage_q.we && !align_q;
  assign wb_rf_waddr = stage_q.waddr;
  assign wb_rf_wdata = stage_q.sel ? ext : stage_q.res;
  assign mem_timeout = timeout_q;
  assign align_err   = wb_valid && align_q;
endmodule

// File: doc/mem_stage_lat.md
Name: mem_stage_lat

Overview:
- Parametrised memory-access pipeline stage between EX and WB.
- Registers the EX result and performs full sub-word load extraction (lb/lbu/lh/lhu/lw, little-endian).
- Tolerates variable data-RAM read latency through a valid handshake and a stall request.
- Drives the WB register and the RF forwarding path.

Parameters:
- DATA_W, 32, datapath/result width; multiple of 32 supported only at 32 in this generation.
- MAX_WAIT, 15, max cycles waited for data_rvalid before timeout; counter width is clog2(MAX_WAIT+1).
- RF_AW, 5, register-file address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  clears stage register and FSM next edge
- hold  in  1  downstream stall; stage register keeps contents
- in_valid  in  1  EX presents an instruction
- in_pc  in  32  instruction PC
- in_mem_op  in  5  one-hot {lb,lbu,lh,lhu,lw}; 0 = non-load
- in_sel_rf_res  in  1  1 = writeback takes load data
- in_rf_we  in  1  RF write enable
- in_rf_waddr  in  RF_AW  destination register
- in_ex_result  in  DATA_W  ALU result / load address
- data_rvalid  in  1  data-RAM read data valid
- data_rdata  in  DATA_W  data-RAM read word
- stall_req  out  1  request upstream freeze
- wb_valid  out  1  instruction valid to WB
- wb_pc  out  32
- wb_rf_we  out  1  gated by wb_valid
- wb_rf_waddr  out  RF_AW
- wb_rf_wdata  out  DATA_W
- mem_timeout  out  1  one-cycle pulse on read timeout
- align_err  out  1  see Optional Feature

Behaviour:
- Reset: stage register 0, FSM IDLE, wait counter 0. All outputs 0.
- Capture priority, per edge: rst > flush (zero, IDLE) > hold or stall_req (keep) > load from in_* (in_valid=0 loads zeros).
- FSM states: IDLE, WAIT, DONE.
- IDLE -> WAIT when a load is captured (in_mem_op!=0 and in_valid).
- WAIT: stall_req=1, wb_valid=0, counter increments each cycle.
  - On data_rvalid=1: latch data_rdata, go DONE.
  - When counter==MAX_WAIT with no rvalid: mem_timeout pulses, latched data=0, go DONE.
- DONE: stall_req=0, wb_valid=1 for exactly that cycle. Next edge returns to IDLE, or to WAIT if the newly captured instruction is a load.
- Non-load captured: wb_valid=1 the cycle after capture, wdata=ex_result. No stall.
- Load latency: wb_valid rises the cycle after the edge sampling data_rvalid=1. Minimum 2 cycles from capture when rvalid arrives first WAIT cycle.
- data_rvalid outside WAIT is ignored.
- Extraction uses off = ex_result[1:0]:
  - lb/lbu: byte off, sign- or zero-extended.
  - lh/lhu: halfword off[1], sign- or zero-extended.
  - lw: full word.
- wb_rf_wdata = sel_rf_res ? extracted : ex_result.
- Forwarding uses the same wb_* signals. wb_rf_we=0 whenever wb_valid=0.
- Flush or rst mid-WAIT: abandon the load, clear the counter, no timeout pulse. The pending rvalid is ignored.
- hold during DONE: outputs remain stable, and wb_valid stays 1 until hold drops.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined: lh/lhu with off[0]=1, or lw with off!=0, skips WAIT.
  - That instruction goes straight to DONE with align_err=1 for its wb_valid cycle.
  - wb_rf_we is forced to 0.
- When undefined: align_err is tied 0, and the misaligned offset bits are ignored (halfword uses off[1], word ignores off).

Test Plan:
- Non-load: addu result 0x0000_1234, we=1, waddr=3 -> next cycle wb_valid=1, wdata=0x1234, stall_req never asserted.
- lb: addr off=2, rdata=0x1280_FF00, rvalid on 1st WAIT cycle -> wdata=0xFFFF_FF80, stall_req high exactly 1 cycle. lbu same -> 0x0000_0080.
- lh: off=2, rdata=0x8001_7FFF, rvalid after 3 WAIT cycles -> stall_req 3 cycles then wdata=0xFFFF_8001. lhu same -> 0x0000_8001.
- Timeout: lw, rvalid never, MAX_WAIT=15 -> mem_timeout pulse after 15 WAIT cycles, wb_valid=1 with wdata=0.
- Flush in 2nd WAIT cycle, then rvalid -> no wb_valid, FSM IDLE, stall_req 0 next cycle.
- With MEM_ALIGN_CHECK_EN: lw at off=1 -> no stall, align_err=1, wb_rf_we=0. Without the macro -> normal lw result.
